multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core. It is the producer side of the ALU control interface: it drives the 3-bit alucontrol code and the operand selects, and consumes the ALU zero flag.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type add/sub/and/or, I-type addi/andi/ori, beq and jal.
- Unsupported encodings trap to a halt state.

Parameters:
- OPW, 7, opcode field width.
- STW, 4, state register width (state exported for debug).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  7  instruction opcode from instruction register (stable from DECODE onward).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- zero  in  1  ALU zero flag.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = result.
- memwrite  out  1  data memory write enable.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file write enable.
- resultsrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 data.
- alusrcb  out  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alucontrol  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or.
- illegal  out  1  high while halted on an unsupported instruction.
- state  out  STW  current state encoding.

Behaviour:
- Registered state, asynchronous clear to FETCH. All outputs are combinational from state, plus zero in BEQ and op/funct in decode paths.
- During and immediately after reset, outputs equal FETCH values:
  - irwrite = 1, pcwrite = 1, adrsrc = 0, alusrca = 00, alusrcb = 10, resultsrc = 10, alucontrol = 000.
  - All other enables 0, illegal = 0.
- Any output not listed for a state is 0.
- States, their outputs, and next state:
  - FETCH: as above; next DECODE.
  - DECODE: alusrca = 01, alusrcb = 01, alucontrol = 000 (computes branch/jump target).
  - MEMADR: alusrca = 10, alusrcb = 01, add. Next MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adrsrc = 1, resultsrc = 00; next MEMWB.
  - MEMWB: resultsrc = 01, regwrite = 1; next FETCH.
  - MEMWRITE: adrsrc = 1, resultsrc = 00, memwrite = 1; next FETCH.
  - EXECUTER: alusrca = 10, alusrcb = 00, alucontrol from funct decode; next ALUWB.
  - EXECUTEI: alusrca = 10, alusrcb = 01, alucontrol from funct decode; next ALUWB.
  - ALUWB: resultsrc = 00, regwrite = 1; next FETCH.
  - BEQ: alusrca = 10, alusrcb = 00, alucontrol = 001, resultsrc = 00, pcwrite = zero; next FETCH.
  - JAL: alusrca = 01, alusrcb = 10, add, resultsrc = 00, pcwrite = 1; next ALUWB.
  - ERROR: illegal = 1, all enables 0; stays in ERROR until rst_n is low.
- DECODE transitions:
  - op 0000011 with funct3 = 010 -> MEMADR.
  - op 0100011 with funct3 = 010 -> MEMADR.
  - op 0110011 with funct3 in {000, 110, 111} -> EXECUTER. funct7b5 is accepted only for funct3 = 000.
  - op 0010011 with funct3 in {000, 110, 111} -> EXECUTEI.
  - op 1100011 with funct3 = 000 -> BEQ.
  - op 1101111 -> JAL.
  - Anything else -> ERROR.
- Funct decode:
  - funct3 = 000: sub (001) if op[5] & funct7b5, else add (000). An I-type with bit30 = 1 therefore adds.
  - funct3 = 110: or (011).
  - funct3 = 111: and (010).
- immsrc is decoded from op in every state:
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.
- Latency in cycles, FETCH through last state: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Never asserted together: memwrite and regwrite; irwrite outside FETCH.
- rst_n low in any state (including mid-MEMWRITE or ERROR) forces FETCH asynchronously; memwrite/regwrite drop immediately.
- zero is sampled only in BEQ. zero toggling in other states has no effect.

Test Plan:
- Reset then lw (op = 0000011, funct3 = 010) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; regwrite = 1 with resultsrc = 01 only in cycle 5.
- sw (0100011, funct3 = 010) -> memwrite = 1, adrsrc = 1 in cycle 4 only; immsrc = 01 throughout; back to FETCH in cycle 5.
- R-type funct3 = 000 with funct7b5 = 1 -> alucontrol = 001 in EXECUTER. Repeat with funct3 = 111 -> 010, and funct3 = 110 -> 011.
- addi with funct7b5 = 1 (0010011, 000) -> alucontrol = 000 in EXECUTEI. beq with zero = 1 -> pcwrite = 1 in BEQ; with zero = 0 -> pcwrite = 0; 3-cycle sequence in both cases.
- jal -> JAL with pcwrite = 1, alusrca = 01, alusrcb = 10, then ALUWB with regwrite = 1. Then op = 0110111 (lui) -> ERROR, illegal = 1, held for 10 cycles with no enables asserted.
- rst_n asserted mid-MEMWRITE (asynchronous, between edges) -> memwrite falls immediately, state = FETCH, illegal = 0. Deassert -> normal fetch resumes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Drives datapath selects/enables and the ALU op; halts on bad opcodes.
module multicycle_ctrl #(
   parameter int OPW = 7,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] op,
   input  logic [2:0]     funct3,
   input  logic           funct7b5,
   input  logic           zero,
   output logic           pcwrite,
   output logic           adrsrc,
   output logic           memwrite,
   output logic           irwrite,
   output logic           regwrite,
   output logic [1:0]     resultsrc,
   output logic [1:0]     alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     immsrc,
   output logic [2:0]     alucontrol,
   output logic           illegal,
   output logic [STW-1:0] state
);

   typedef enum logic [STW-1:0] {
      FETCH    = STW'(0),
      DECODE   = STW'(1),
      MEMADR   = STW'(2),
      MEMREAD  = STW'(3),
      MEMWB    = STW'(4),
      MEMWRITE = STW'(5),
      EXECUTER = STW'(6),
      EXECUTEI = STW'(7),
      ALUWB    = STW'(8),
      BEQ      = STW'(9),
      JAL      = STW'(10),
      ERROR    = STW'(11)
   } state_t;

   localparam logic [OPW-1:0] OP_LW   = OPW'(7'b0000011);
   localparam logic [OPW-1:0] OP_SW   = OPW'(7'b0100011);
   localparam logic [OPW-1:0] OP_R    = OPW'(7'b0110011);
   localparam logic [OPW-1:0] OP_I    = OPW'(7'b0010011);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(7'b1100011);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(7'b1101111);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   state_t state_q, state_d, dec_next;
   logic [2:0] alu_fn;
   logic f3_alu, r_ok;

   // add/or/and are the only funct3 values the ALU paths accept
   assign f3_alu = (funct3 == 3'b000) | (funct3 == 3'b110)
                 | (funct3 == 3'b111);
   // bit30 only distinguishes sub from add; elsewhere it is illegal
   assign r_ok   = f3_alu & ((funct3 == 3'b000) | ~funct7b5);
   assign state  = state_q;

   // state register, async clear to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // opcode dispatch out of DECODE
   always_comb begin
      dec_next = ERROR;
      unique case (1'b1)
         (op == OP_LW) && (funct3 == 3'b010): dec_next = MEMADR;
         (op == OP_SW) && (funct3 == 3'b010): dec_next = MEMADR;
         (op == OP_R) && r_ok:                dec_next = EXECUTER;
         (op == OP_I) && f3_alu:              dec_next = EXECUTEI;
         (op == OP_BEQ) && (funct3 == 3'b000): dec_next = BEQ;
         (op == OP_JAL):                      dec_next = JAL;
         default:                             dec_next = ERROR;
      endcase
   end

   // ALU op for register and immediate arithmetic
   always_comb begin
      alu_fn = ALU_ADD;
      unique case (funct3)
         3'b000:  alu_fn = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
         3'b110:  alu_fn = ALU_OR;
         3'b111:  alu_fn = ALU_AND;
         default: alu_fn = ALU_ADD;
      endcase
   end

   // immediate format follows the opcode in every state
   always_comb begin
      immsrc = 2'b00;
      unique case (1'b1)
         op == OP_SW:  immsrc = 2'b01;
         op == OP_BEQ: immsrc = 2'b10;
         op == OP_JAL: immsrc = 2'b11;
         default:      immsrc = 2'b00;
      endcase
   end

   // next state and per-state datapath controls
   always_comb begin
      state_d    = state_q;
      pcwrite    = 1'b0;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
      unique case (state_q)
         FETCH: begin
            irwrite   = 1'b1;
            pcwrite   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            state_d   = DECODE;
         end
         DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            state_d = dec_next;
         end
         MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            state_d  = FETCH;
         end
         EXECUTER: begin
            alusrca    = 2'b10;
            alucontrol = alu_fn;
            state_d    = ALUWB;
         end
         EXECUTEI: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            alucontrol = alu_fn;
            state_d    = ALUWB;
         end
         ALUWB: begin
            regwrite = 1'b1;
            state_d  = FETCH;
         end
         BEQ: begin
            alusrca    = 2'b10;
            alucontrol = ALU_SUB;
            pcwrite    = zero;
            state_d    = FETCH;
         end
         JAL: begin
            alusrca = 2'b01;
            alusrcb = 2'b10;
            pcwrite = 1'b1;
            state_d = ALUWB;
         end
         default: begin
            illegal = 1'b1;
            state_d = ERROR;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for the multicycle control FSM.
// Walks each instruction class and the reset/halt corner cases.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.OPW(7), .STW(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .pcwrite(pcwrite),
      .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
      .regwrite(regwrite), .resultsrc(resultsrc),
      .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
      .alucontrol(alucontrol), .illegal(illegal), .state(state)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   localparam logic [3:0] S_FE = 4'd0,  S_DE = 4'd1,  S_MA = 4'd2;
   localparam logic [3:0] S_MR = 4'd3,  S_MB = 4'd4,  S_MW = 4'd5;
   localparam logic [3:0] S_XR = 4'd6,  S_XI = 4'd7,  S_AW = 4'd8;
   localparam logic [3:0] S_BQ = 4'd9,  S_JL = 4'd10, S_ER = 4'd11;

   // {pcw,adr,mw,irw,rw,rsrc,asa,asb,imm,alu,ill,state}
   function automatic logic [20:0] mk(
      input logic [3:0] st, input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic rw,
      input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic [1:0] im,
      input logic [2:0] al, input logic il);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, im, al, il, st};
   endfunction

   function automatic logic [20:0] fetch_v(input logic [1:0] im);
      return mk(S_FE, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im,
                3'b000, 0);
   endfunction

   function automatic logic [20:0] dec_v(input logic [1:0] im);
      return mk(S_DE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im,
                3'b000, 0);
   endfunction

   function automatic logic [20:0] aluwb_v(input logic [1:0] im);
      return mk(S_AW, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im,
                3'b000, 0);
   endfunction

   task automatic chk(input string tag, input logic [20:0] exp);
      logic [20:0] got;
      got = {pcwrite, adrsrc, memwrite, irwrite, regwrite,
             resultsrc, alusrca, alusrcb, immsrc, alucontrol,
             illegal, state};
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7);
      op = o;
      funct3 = f3;
      funct7b5 = f7;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      op = 7'b0000011;
      funct3 = 3'b010;
      funct7b5 = 1'b0;
      zero = 1'b0;
      #8;
      chk("reset_fetch", fetch_v(2'b00));
      #14;
      rst_n = 1'b1;
      #1;
      // lw: 5 cycles
      chk("lw_fetch", fetch_v(2'b00));
      tick(); chk("lw_decode", dec_v(2'b00));
      tick(); chk("lw_memadr", mk(S_MA, 0, 0, 0, 0, 0, 2'b00,
                                  2'b10, 2'b01, 2'b00, 3'b000, 0));
      tick(); chk("lw_memread", mk(S_MR, 0, 1, 0, 0, 0, 2'b00,
                                   2'b00, 2'b00, 2'b00, 3'b000, 0));
      tick(); chk("lw_memwb", mk(S_MB, 0, 0, 0, 0, 1, 2'b01,
                                 2'b00, 2'b00, 2'b00, 3'b000, 0));
      tick();
      // sw: 4 cycles, S-format immediate throughout
      set_in(7'b0100011, 3'b010, 1'b0);
      chk("sw_fetch", fetch_v(2'b01));
      tick(); chk("sw_decode", dec_v(2'b01));
      tick(); chk("sw_memadr", mk(S_MA, 0, 0, 0, 0, 0, 2'b00,
                                  2'b10, 2'b01, 2'b01, 3'b000, 0));
      tick(); chk("sw_memwrite", mk(S_MW, 0, 1, 1, 0, 0, 2'b00,
                                    2'b00, 2'b00, 2'b01, 3'b000, 0));
      tick(); chk("sw_back_fetch", fetch_v(2'b01));
      // sub
      set_in(7'b0110011, 3'b000, 1'b1);
      tick(); chk("sub_decode", dec_v(2'b00));
      tick(); chk("sub_exec", mk(S_XR, 0, 0, 0, 0, 0, 2'b00,
                                 2'b10, 2'b00, 2'b00, 3'b001, 0));
      tick(); chk("sub_aluwb", aluwb_v(2'b00));
      tick(); chk("sub_fetch", fetch_v(2'b00));
      // and
      set_in(7'b0110011, 3'b111, 1'b0);
      tick(); tick();
      chk("and_exec", mk(S_XR, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                         2'b00, 2'b00, 3'b010, 0));
      tick(); tick();
      // or
      set_in(7'b0110011, 3'b110, 1'b0);
      tick(); tick();
      chk("or_exec", mk(S_XR, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                        2'b00, 2'b00, 3'b011, 0));
      tick(); tick();
      // addi with bit30 set still adds
      set_in(7'b0010011, 3'b000, 1'b1);
      tick(); tick();
      chk("addi_exec", mk(S_XI, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                          2'b01, 2'b00, 3'b000, 0));
      tick(); chk("addi_aluwb", aluwb_v(2'b00));
      tick();
      // ori
      set_in(7'b0010011, 3'b110, 1'b0);
      tick(); tick();
      chk("ori_exec", mk(S_XI, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                         2'b01, 2'b00, 3'b011, 0));
      tick(); tick();
      // beq taken: zero high everywhere, only BEQ uses it
      set_in(7'b1100011, 3'b000, 1'b0);
      zero = 1'b1;
      #1;
      chk("beq1_fetch", fetch_v(2'b10));
      tick(); chk("beq1_decode", dec_v(2'b10));
      tick(); chk("beq1_beq", mk(S_BQ, 1, 0, 0, 0, 0, 2'b00,
                                 2'b10, 2'b00, 2'b10, 3'b001, 0));
      tick(); chk("beq1_fetch2", fetch_v(2'b10));
      // beq not taken
      zero = 1'b0;
      tick(); chk("beq0_decode", dec_v(2'b10));
      tick(); chk("beq0_beq", mk(S_BQ, 0, 0, 0, 0, 0, 2'b00,
                                 2'b10, 2'b00, 2'b10, 3'b001, 0));
      tick(); chk("beq0_fetch", fetch_v(2'b10));
      // jal
      set_in(7'b1101111, 3'b000, 1'b0);
      tick(); chk("jal_decode", dec_v(2'b11));
      tick(); chk("jal_jal", mk(S_JL, 1, 0, 0, 0, 0, 2'b00,
                                2'b01, 2'b10, 2'b11, 3'b000, 0));
      tick(); chk("jal_aluwb", aluwb_v(2'b11));
      tick(); chk("jal_fetch", fetch_v(2'b11));
      // lui is unsupported: halt
      set_in(7'b0110111, 3'b000, 1'b0);
      tick(); chk("lui_decode", dec_v(2'b00));
      for (int i = 0; i < 10; i++) begin
         zero = i[0];
         tick();
         chk("lui_error", mk(S_ER, 0, 0, 0, 0, 0, 2'b00, 2'b00,
                             2'b00, 2'b00, 3'b000, 1));
      end
      // reset out of ERROR
      #2 rst_n = 1'b0;
      #1 chk("err_reset", fetch_v(2'b00));
      @(negedge clk);
      rst_n = 1'b1;
      // and with bit30 set is illegal
      set_in(7'b0110011, 3'b111, 1'b1);
      tick(); chk("andb30_decode", dec_v(2'b00));
      tick(); chk("andb30_error", mk(S_ER, 0, 0, 0, 0, 0, 2'b00,
                                     2'b00, 2'b00, 2'b00, 3'b000, 1));
      #2 rst_n = 1'b0;
      #1 chk("err_reset2", fetch_v(2'b00));
      @(negedge clk);
      rst_n = 1'b1;
      // reset between edges in MEMWRITE
      set_in(7'b0100011, 3'b010, 1'b0);
      tick(); tick(); tick();
      chk("sw2_memwrite", mk(S_MW, 0, 1, 1, 0, 0, 2'b00, 2'b00,
                             2'b00, 2'b01, 3'b000, 0));
      #2 rst_n = 1'b0;
      #1 chk("mw_async_reset", fetch_v(2'b01));
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("resume_fetch", fetch_v(2'b01));
      tick(); chk("resume_decode", dec_v(2'b01));
      tick(); chk("resume_memadr", mk(S_MA, 0, 0, 0, 0, 0, 2'b00,
                                      2'b10, 2'b01, 2'b01, 3'b000, 0));
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
